serial_addsub_resp: RTL and testbench
=====================================

Name: serial_addsub_resp

Overview:
Sequential, bit-serial signed add/subtract responder. It is the DUT end of the operand/result exchange that the lab pattern bench drives. It accepts one operand pair plus opt through a valid/ready handshake, computes LSB-first one bit per clock, then returns a WIDTH-bit two's-complement result with an overflow flag and a one-cycle out_valid pulse.

Parameters:
WIDTH, 4, operand and result width in bits (two's complement); legal range 2..16.
CNT_W, $clog2(WIDTH), width of the internal bit counter.

Ports:
CLK  input  1  system clock, rising-edge active
RST  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands (high only in IDLE)
in_n0  input  WIDTH  first operand, signed
in_n1  input  WIDTH  second operand, signed
opt  input  1  0: in_n0+in_n1, 1: in_n0-in_n1
out_valid  output  1  result valid, exactly one-cycle pulse
out_n  output  WIDTH  result modulo 2^WIDTH, held between results
out_ovf  output  1  signed overflow of the last result, held with out_n

Behaviour:
- Reset (async, RST=1): state=IDLE; in_ready=1, out_valid=0, out_n=0, out_ovf=0; the counter, carry and shift register are all cleared.
- States: IDLE, CALC, DONE. All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- IDLE: in_ready=1. At an edge where in_valid&&in_ready:
  - capture a=in_n0, b=(opt ? ~in_n1 : in_n1), carry=opt;
  - clear bit_cnt and go to CALC.
  - in_valid=0 keeps the block in IDLE.
- CALC: in_ready=0. Each edge:
  - sum_bit = a[bit_cnt]^b[bit_cnt]^carry, shifted into result from the MSB side (LSB-first);
  - carry updates to the full-adder carry out;
  - the carry into the MSB is stored when bit_cnt==WIDTH-1.
  - When bit_cnt==WIDTH-1, go to DONE and load out_n with the completed result and out_ovf = c_in_msb ^ c_out_msb.
  - Otherwise bit_cnt increments.
- DONE: out_valid=1 for exactly this cycle and in_ready=0; the next edge returns to IDLE.
- Latency: if the capture edge is e0, out_valid is high between edges e_WIDTH and e_WIDTH+1. Minimum initiation interval is WIDTH+2 cycles. For WIDTH=4, the result is valid 4 cycles after capture.
- in_valid while in CALC/DONE is ignored; no queueing and no error flag. The bench must hold in_valid until it sees in_ready.
- Operands and opt are sampled only at the capture edge. Later input changes do not affect the in-flight result.
- out_n/out_ovf change only on entry to DONE. They hold otherwise, including through later IDLE cycles.
- Arithmetic wraps modulo 2^WIDTH. out_ovf=1 iff the true signed result lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Reset asserted mid-CALC or DONE aborts the operation: no out_valid, outputs return to reset values, and the block is in IDLE on the first edge after deassertion.

Decomposition:
- Package addsub_pkg:
  - state enum {IDLE, CALC, DONE};
  - opt encodings OPT_ADD=1'b0, OPT_SUB=1'b1;
  - default WIDTH constant.
- One natural sub-module: full_adder_bit (a, b, cin -> s, cout), instantiated once and reused every CALC cycle.

Test Plan:
- Reset then idle → in_ready=1, out_valid=0, out_n=4'h0, out_ovf=0 with no in_valid applied.
- in_n0=3, in_n1=4, opt=0 → out_valid pulse exactly 4 cycles after capture, out_n=4'h7, out_ovf=0; in_ready low for 5 cycles.
- in_n0=5, in_n1=7, opt=1 → out_n=4'hE (-2), out_ovf=0; in_n0=7, in_n1=7, opt=0 → out_n=4'hE, out_ovf=1.
- in_n0=4'h8 (-8), in_n1=1, opt=1 → out_n=4'h7, out_ovf=1. Change in_n0/in_n1 and pulse in_valid during CALC → result unchanged, no second out_valid.
- Assert RST two cycles into CALC → out_valid never pulses, out_n=0, in_ready=1 the cycle after release; the next transaction 2+2 → 4'h4.
- 1000 random back-to-back transactions with in_n0/in_n1 in 0..7 and random opt → every out_n matches the model ((n0±n1) mod 16), every out_valid is a single cycle, and the interval between captures is ≥6 cycles.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the bit-serial signed add/subtract responder.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OPT_ADD = 1'b0;
    localparam logic OPT_SUB = 1'b1;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_adder_bit.sv
// Single-bit full adder, reused once per clock by the serial datapath.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_resp.sv
// Bit-serial signed add/subtract responder: captures an operand pair, computes
// LSB-first one bit per clock, and returns a registered result plus overflow flag.
module serial_addsub_resp
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_n0,
    input  logic [WIDTH-1:0] in_n1,
    input  logic             opt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_n,
    output logic             out_ovf
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   out_n_q, out_n_d;
    logic               out_ovf_q, out_ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    logic               fa_s;
    logic               fa_cout;
    logic               last_bit;

    full_adder_bit u_fa (
        .a    (a_q[bit_cnt_q]),
        .b    (b_q[bit_cnt_q]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

    // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        bit_cnt_d   = bit_cnt_q;
        res_d       = res_q;
        out_n_d     = out_n_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = 1'b0;
        in_ready_d  = in_ready_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = in_n0;
                    b_d        = (opt == OPT_SUB) ? ~in_n1 : in_n1;
                    carry_d    = opt;
                    bit_cnt_d  = '0;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                if (last_bit) begin
                    out_n_d     = {fa_s, res_q[WIDTH-1:1]};
                    out_ovf_d   = carry_q ^ fa_cout;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                in_ready_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                in_ready_d = 1'b1;
                state_d    = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            bit_cnt_q   <= '0;
            res_q       <= '0;
            out_n_q     <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            bit_cnt_q   <= bit_cnt_d;
            res_q       <= res_d;
            out_n_q     <= out_n_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_n     = out_n_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_addsub_resp.sv
// Self-checking bench for serial_addsub_resp: vector table, hand-written
// corner sequences and random back-to-back traffic checked through a scoreboard.
module tb_serial_addsub_resp;

    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RST;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_n0;
    logic [W-1:0] in_n1;
    logic         opt;
    logic         out_valid;
    logic [W-1:0] out_n;
    logic         out_ovf;

    typedef struct {
        logic [W-1:0] n0;
        logic [W-1:0] n1;
        logic         op;
        logic [W-1:0] exp_n;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] n;
        logic         ovf;
        int           cap;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastCap = -1;
    logic checkInterval = 1'b0;
    logic prevValid = 1'b0;

    serial_addsub_resp #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_n0     (in_n0),
        .in_n1     (in_n1),
        .opt       (opt),
        .out_valid (out_valid),
        .out_n     (out_n),
        .out_ovf   (out_ovf)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every out_valid must match the oldest pending result.
    always @(negedge CLK) begin
        if (out_valid === 1'b1) begin
            checkOutput("single_cycle_pulse", {31'd0, prevValid}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_out_valid: got out_n=%0h with no pending result at cycle %0d", out_n, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_n", {28'd0, out_n}, {28'd0, e.n});
                checkOutput("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
                checkOutput("latency", cyc - e.cap, W);
            end
        end
        prevValid <= out_valid;
    end

    task automatic applyStimulus(input logic [W-1:0] n0, input logic [W-1:0] n1, input logic op,
                                 input logic [W-1:0] expN, input logic expOvf);
        int w;
        exp_t e;
        in_n0    = n0;
        in_n1    = n1;
        opt      = op;
        in_valid = 1'b1;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL in_ready_timeout: got in_ready=%b expected 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        e.n   = expN;
        e.ovf = expOvf;
        e.cap = cyc;
        sb.push_back(e);
        if (checkInterval && lastCap >= 0) begin
            checks++;
            if (cyc - lastCap < W + 2) begin
                errors++;
                $display("[TB] FAIL capture_interval: got %0d expected >= %0d", cyc - lastCap, W + 2);
            end
        end
        lastCap = cyc;
    endtask

    task automatic waitDrain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge CLK);
            w++;
        end
        @(negedge CLK);
        checkOutput("scoreboard_drained", sb.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{4'h3, 4'h4, 1'b0, 4'h7, 1'b0};
        vecs[1] = '{4'h5, 4'h7, 1'b1, 4'hE, 1'b0};
        vecs[2] = '{4'h7, 4'h7, 1'b0, 4'hE, 1'b1};
        vecs[3] = '{4'h8, 4'h1, 1'b1, 4'h7, 1'b1};
        vecs[4] = '{4'h2, 4'h2, 1'b0, 4'h4, 1'b0};
        vecs[5] = '{4'h8, 4'h8, 1'b0, 4'h0, 1'b1};
        vecs[6] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0};
        vecs[7] = '{4'h7, 4'h8, 1'b1, 4'hF, 1'b1};
        vecs[8] = '{4'h8, 4'h7, 1'b0, 4'hF, 1'b0};
        vecs[9] = '{4'h6, 4'h3, 1'b1, 4'h3, 1'b0};

        RST      = 1'b1;
        in_valid = 1'b0;
        in_n0    = '0;
        in_n1    = '0;
        opt      = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_n", {28'd0, out_n}, 32'd0);
        checkOutput("reset_out_ovf", {31'd0, out_ovf}, 32'd0);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("idle_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("idle_out_n", {28'd0, out_n}, 32'd0);

        // First vector by hand: in_ready must stay low for exactly WIDTH+1 cycles.
        applyStimulus(vecs[0].n0, vecs[0].n1, vecs[0].op, vecs[0].exp_n, vecs[0].exp_ovf);
        for (int i = 0; i < W + 1; i++) begin
            @(negedge CLK);
            checkOutput("busy_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(negedge CLK);
        checkOutput("ready_again", {31'd0, in_ready}, 32'd1);
        checkOutput("held_out_n", {28'd0, out_n}, {28'd0, vecs[0].exp_n});
        waitDrain();

        for (int i = 1; i < 10; i++) begin
            applyStimulus(vecs[i].n0, vecs[i].n1, vecs[i].op, vecs[i].exp_n, vecs[i].exp_ovf);
        end
        waitDrain();

        // Inputs changing and in_valid pulsing mid-calculation must be ignored.
        applyStimulus(4'h8, 4'h1, 1'b1, 4'h7, 1'b1);
        @(negedge CLK);
        in_n0    = 4'h3;
        in_n1    = 4'h3;
        opt      = 1'b0;
        in_valid = 1'b1;
        repeat (2) @(negedge CLK);
        in_valid = 1'b0;
        waitDrain();
        repeat (8) @(negedge CLK);
        checkOutput("held_after_idle_n", {28'd0, out_n}, 32'd7);
        checkOutput("held_after_idle_ovf", {31'd0, out_ovf}, 32'd1);

        // Reset two cycles into CALC aborts the operation.
        applyStimulus(4'h2, 4'h2, 1'b0, 4'h4, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        sb.delete();
        @(negedge CLK);
        checkOutput("abort_out_n", {28'd0, out_n}, 32'd0);
        checkOutput("abort_out_ovf", {31'd0, out_ovf}, 32'd0);
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge CLK);
        applyStimulus(4'h2, 4'h2, 1'b0, 4'h4, 1'b0);
        waitDrain();

        // Random back-to-back traffic against a signed arithmetic model.
        lastCap       = -1;
        checkInterval = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int a, b, s;
            logic op;
            logic [31:0] sv;
            a  = $urandom_range(0, 7);
            b  = $urandom_range(0, 7);
            op = 1'($urandom_range(0, 1));
            s  = op ? (a - b) : (a + b);
            sv = s;
            applyStimulus(W'(a), W'(b), op, sv[W-1:0], (s > 7) || (s < -8));
        end
        checkInterval = 1'b0;
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
